// File: rtl/alu_ctrl_32_if.sv
// Request/result bundle between an operation requester and alu_ctrl_32,
// together with the operand/result path to the external ALU. The master
// side is the requester plus the ALU; the slave side is the controller.
interface alu_ctrl_32_if;
    logic        in_start;
    logic [3:0]  in_opcode;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [63:0] in_alu_result;

    logic        out_ready;
    logic        out_done;
    logic        out_err;
    logic [31:0] out_hi;
    logic [31:0] out_lo;
    logic [31:0] out_alu_a;
    logic [31:0] out_alu_b;
    logic [3:0]  out_alu_opcode;
    logic        out_alu_div_reset;

    modport master (
        output in_start, in_opcode, in_a, in_b, in_alu_result,
        input  out_ready, out_done, out_err, out_hi, out_lo,
               out_alu_a, out_alu_b, out_alu_opcode, out_alu_div_reset
    );

    modport slave (
        input  in_start, in_opcode, in_a, in_b, in_alu_result,
        output out_ready, out_done, out_err, out_hi, out_lo,
               out_alu_a, out_alu_b, out_alu_opcode, out_alu_div_reset
    );
endinterface

// File: rtl/alu_ctrl_32.sv
// Sequencing controller for a 32-bit ALU with a multi-cycle divider.
// Latches one request at a time, drives the ALU operands, waits for the
// result (one cycle for ordinary ops, a reset pulse plus DIV_CYCLES for
// divide) and presents it with a one-cycle done pulse. Divide-by-zero and
// illegal opcodes complete immediately with the error flag set.
module alu_ctrl_32 #(
    parameter int DIV_CYCLES = 32
) (
    input  logic          clk,
    input  logic          in_reset_n,
    alu_ctrl_32_if.slave  bus
);

    localparam logic [3:0] OP_DIV = 4'b1001;
    localparam int         CNT_W  = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_DIV_INIT,
        S_DIV_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Opcodes 1100-1111 have no ALU operation behind them.
    function automatic logic is_illegal(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

    // Control FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state                 <= S_IDLE;
            cnt                   <= '0;
            bus.out_ready         <= 1'b1;
            bus.out_done          <= 1'b0;
            bus.out_err           <= 1'b0;
            bus.out_hi            <= '0;
            bus.out_lo            <= '0;
            bus.out_alu_a         <= '0;
            bus.out_alu_b         <= '0;
            bus.out_alu_opcode    <= '0;
            bus.out_alu_div_reset <= 1'b0;
        end else begin
            // Pulses default low; only the states below raise them.
            bus.out_done          <= 1'b0;
            bus.out_alu_div_reset <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.in_start) begin
                        bus.out_alu_a      <= bus.in_a;
                        bus.out_alu_b      <= bus.in_b;
                        bus.out_alu_opcode <= bus.in_opcode;
                        bus.out_ready      <= 1'b0;
                        if (is_illegal(bus.in_opcode)) begin
                            bus.out_hi   <= '0;
                            bus.out_lo   <= '0;
                            bus.out_err  <= 1'b1;
                            bus.out_done <= 1'b1;
                            state        <= S_DONE;
                        end else if (bus.in_opcode == OP_DIV) begin
                            if (bus.in_b == '0) begin
                                // Divider is never started on a zero divisor.
                                bus.out_hi   <= bus.in_a;
                                bus.out_lo   <= '1;
                                bus.out_err  <= 1'b1;
                                bus.out_done <= 1'b1;
                                state        <= S_DONE;
                            end else begin
                                bus.out_alu_div_reset <= 1'b1;
                                state                 <= S_DIV_INIT;
                            end
                        end else begin
                            state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    bus.out_hi   <= bus.in_alu_result[63:32];
                    bus.out_lo   <= bus.in_alu_result[31:0];
                    bus.out_err  <= 1'b0;
                    bus.out_done <= 1'b1;
                    state        <= S_DONE;
                end
                S_DIV_INIT: begin
                    cnt   <= '0;
                    state <= S_DIV_WAIT;
                end
                S_DIV_WAIT: begin
                    if (cnt == CNT_LAST) begin
                        bus.out_hi   <= bus.in_alu_result[63:32];
                        bus.out_lo   <= bus.in_alu_result[31:0];
                        bus.out_err  <= 1'b0;
                        bus.out_done <= 1'b1;
                        state        <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    bus.out_ready <= 1'b1;
                    state         <= S_IDLE;
                end
                default: begin
                    bus.out_ready <= 1'b1;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_32.sv
// Bench for alu_ctrl_32: an ALU/divider stand-in, a transaction-level model
// of the controller's externally visible behaviour, a per-cycle compare
// process and directed operations with hand-computed results.
module tb_alu_ctrl_32;

    localparam int DIV_CYCLES = 32;
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b1001;
    localparam logic [3:0] OP_NOT = 4'b1011;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_ctrl_32_if bus ();

    alu_ctrl_32 #(.DIV_CYCLES(DIV_CYCLES)) dut (
        .clk        (clk),
        .in_reset_n (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Reference ALU: what the 64-bit result bus carries for a settled operation.
    function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            OP_ADD:  return {32'h0, a + b};
            OP_SUB:  return {32'h0, a - b};
            OP_MUL:  return {32'h0, a} * {32'h0, b};
            OP_DIV:  return (b == 0) ? 64'h0 : {a % b, a / b};
            OP_NOT:  return {32'h0, ~a};
            default: return {a ^ b, a | b};
        endcase
    endfunction

    // Divider stand-in: result only becomes meaningful DIV_CYCLES cycles after the reset pulse.
    logic [15:0] dcnt = 16'd0;
    always @(posedge clk) begin
        if (bus.out_alu_div_reset) dcnt <= 16'd0;
        else if (dcnt != 16'hFFFF) dcnt <= dcnt + 16'd1;
    end

    // ALU result path, combinational from the registered operands.
    always_comb begin
        bus.in_alu_result = ref_alu(bus.out_alu_opcode, bus.out_alu_a, bus.out_alu_b);
        if (bus.out_alu_opcode == OP_DIV && int'(dcnt) < DIV_CYCLES - 1)
            bus.in_alu_result = 64'hBAD0_BAD0_BAD0_BAD0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: busy/idle, edges remaining until completion, expected outputs.
    logic        m_idle = 1'b1, m_done = 1'b0, m_divrst = 1'b0, m_err = 1'b0, p_err = 1'b0;
    int          m_rem = 0;
    logic [31:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0;
    logic [3:0]  m_op = '0;
    logic [63:0] p_res = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle = 1'b1; m_done = 1'b0; m_divrst = 1'b0; m_rem = 0;
            m_hi = '0; m_lo = '0; m_err = 1'b0; m_a = '0; m_b = '0; m_op = '0;
        end else begin
            m_divrst = 1'b0;
            if (m_done) begin
                m_done = 1'b0;
                m_idle = 1'b1;
            end else if (m_idle) begin
                if (bus.in_start) begin
                    m_a = bus.in_a; m_b = bus.in_b; m_op = bus.in_opcode;
                    m_idle = 1'b0;
                    if (m_op >= 4'b1100) begin
                        p_res = 64'h0; p_err = 1'b1; m_rem = 0;
                    end else if (m_op == OP_DIV && m_b == 0) begin
                        p_res = {m_a, 32'hFFFF_FFFF}; p_err = 1'b1; m_rem = 0;
                    end else begin
                        p_res = ref_alu(m_op, m_a, m_b); p_err = 1'b0;
                        m_rem = (m_op == OP_DIV) ? DIV_CYCLES + 1 : 1;
                        m_divrst = (m_op == OP_DIV);
                    end
                    if (m_rem == 0) begin
                        {m_hi, m_lo} = p_res; m_err = p_err; m_done = 1'b1;
                    end
                end
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    {m_hi, m_lo} = p_res; m_err = p_err; m_done = 1'b1;
                end
            end
        end
    end

    // Compare every DUT output against the model once per cycle.
    always @(negedge clk) begin
        chk("ready",     64'(bus.out_ready),         64'(m_idle));
        chk("done",      64'(bus.out_done),          64'(m_done));
        chk("err",       64'(bus.out_err),           64'(m_err));
        chk("hi",        64'(bus.out_hi),            64'(m_hi));
        chk("lo",        64'(bus.out_lo),            64'(m_lo));
        chk("alu_a",     64'(bus.out_alu_a),         64'(m_a));
        chk("alu_b",     64'(bus.out_alu_b),         64'(m_b));
        chk("alu_op",    64'(bus.out_alu_opcode),    64'(m_op));
        chk("div_reset", 64'(bus.out_alu_div_reset), 64'(m_divrst));
    end

    // Wait (bounded) for ready, issue one op, scramble inputs, wait for done.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] hi, output logic [31:0] lo,
                          output logic err, output int pulses);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.out_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", 64'(n >= 200), 64'd0);
        bus.in_start = 1'b1; bus.in_opcode = op; bus.in_a = a; bus.in_b = b;
        @(negedge clk);
        bus.in_start = 1'b0; bus.in_a = $urandom; bus.in_b = $urandom; bus.in_opcode = 4'($urandom);
        lat = 0;
        pulses = 0;
        while (!bus.out_done && lat < 100) begin
            pulses += int'(bus.out_alu_div_reset);
            @(negedge clk);
            lat++;
        end
        chk("done_timeout", 64'(lat >= 100), 64'd0);
        hi = bus.out_hi; lo = bus.out_lo; err = bus.out_err;
    endtask

    int          lat, pulses, ndone;
    logic [31:0] hi, lo;
    logic        err;

    initial begin
        bus.in_start = 1'b0; bus.in_opcode = '0; bus.in_a = '0; bus.in_b = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready", 64'(bus.out_ready), 64'd1);
        chk("rst_done",  64'(bus.out_done),  64'd0);
        chk("rst_hilo",  {bus.out_hi, bus.out_lo}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_op(OP_ADD, 32'h0000_FFFF, 32'h0000_0001, lat, hi, lo, err, pulses);
        chk("add_lat", 64'(lat), 64'd1);
        chk("add_lo",  64'(lo),  64'h0001_0000);
        chk("add_hi",  64'(hi),  64'd0);
        chk("add_err", 64'(err), 64'd0);

        run_op(OP_MUL, 32'hFFFF_FFF3, 32'h0000_000B, lat, hi, lo, err, pulses);
        chk("mul_lat", 64'(lat), 64'd1);
        chk("mul_res", {hi, lo}, 64'h0000_000A_FFFF_FF71);
        chk("mul_err", 64'(err), 64'd0);

        run_op(OP_DIV, 32'd100, 32'd7, lat, hi, lo, err, pulses);
        chk("div_lat",    64'(lat),    64'd33);
        chk("div_pulses", 64'(pulses), 64'd1);
        chk("div_quot",   64'(lo),     64'd14);
        chk("div_rem",    64'(hi),     64'd2);
        chk("div_err",    64'(err),    64'd0);

        run_op(OP_DIV, 32'd5, 32'd0, lat, hi, lo, err, pulses);
        chk("dz_lat",    64'(lat),    64'd0);
        chk("dz_pulses", 64'(pulses), 64'd0);
        chk("dz_res",    {hi, lo},    64'h0000_0005_FFFF_FFFF);
        chk("dz_err",    64'(err),    64'd1);

        run_op(4'b1100, 32'h1234_5678, 32'h9ABC_DEF0, lat, hi, lo, err, pulses);
        chk("ill_lat", 64'(lat), 64'd0);
        chk("ill_res", {hi, lo}, 64'd0);
        chk("ill_err", 64'(err), 64'd1);

        run_op(OP_NOT, 32'h0F0F_0000, 32'h0, lat, hi, lo, err, pulses);
        chk("not_lo", 64'(lo), 64'hF0F0_FFFF);

        run_op(OP_SUB, 32'd3, 32'd5, lat, hi, lo, err, pulses);
        chk("sub_lo", 64'(lo), 64'hFFFF_FFFE);

        // Reset during DIV_WAIT cycle 10, then a normal ADD.
        @(negedge clk);
        bus.in_start = 1'b1; bus.in_opcode = OP_DIV; bus.in_a = 32'd100; bus.in_b = 32'd7;
        @(negedge clk);
        bus.in_start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(bus.out_ready), 64'd1);
        chk("mid_rst_done",  64'(bus.out_done),  64'd0);
        chk("mid_rst_out",   {bus.out_hi, bus.out_lo}, 64'd0);
        chk("mid_rst_alu",   {bus.out_alu_a, bus.out_alu_b}, 64'd0);
        chk("mid_rst_misc",  64'({bus.out_alu_opcode, bus.out_alu_div_reset, bus.out_err}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(bus.out_ready), 64'd1);
        run_op(OP_ADD, 32'd3, 32'd4, lat, hi, lo, err, pulses);
        chk("post_rst_add", {hi, lo}, 64'd7);
        chk("post_rst_lat", 64'(lat), 64'd1);

        // Start held high with operands changing every cycle: one accept per IDLE visit.
        while (!bus.out_ready) @(negedge clk);
        ndone = 0;
        bus.in_start = 1'b1; bus.in_opcode = OP_ADD; bus.in_a = 32'd1000; bus.in_b = 32'd1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ndone += int'(bus.out_done);
            bus.in_a = 32'd1000 + 32'(i) * 32'd17;
            bus.in_b = 32'(i) + 32'd2;
            if (i == 29) bus.in_start = 1'b0;
        end
        chk("held_start_dones", 64'(ndone), 64'd10);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
